// File: rtl/mips_mem_pkg.sv
// Shared memory-subsystem definitions: word width, default store-buffer depth,
// word-index geometry used by the store buffer, data memory and MEM stage.
package mips_mem_pkg;

  localparam int SB_DEPTH = 4;   // default store-buffer entries
  localparam int WORD_W   = 32;  // data word width
  localparam int ADDR_W   = 32;  // default byte-address width
  localparam int WORD_LSB = 2;   // byte-offset bits dropped for word indexing

  // Width of a word index for a given byte-address width
  function automatic int widx_w(input int aw);
    return aw - WORD_LSB;
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match forwarding search over the valid store-buffer entries.
// Entries are visited from tail-1 back to head; the first match wins.
module sb_fwd_match
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int WA_W  = ADDR_W - WORD_LSB,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WA_W-1:0]   ent_addr,
  input  logic [DEPTH-1:0][WORD_W-1:0] ent_data,
  input  logic [PW-1:0]                head,
  input  logic [PW:0]                  count,
  input  logic [WA_W-1:0]              key,
  output logic                         hit,
  output logic [WORD_W-1:0]            data
);

  logic [PW-1:0] idx;

  // Priority search: offset count-1 (youngest) first, down to offset 0 (head)
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = head + PW'(k);
      if (!hit && ((PW + 1)'(k) < count) && (ent_addr[idx] == key)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer between the MEM-stage load/store port and a single-port
// data memory. Stores queue in a FIFO and retire in order whenever the port is
// free; loads go to memory directly, with youngest-match forwarding.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              sb_empty,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int PW   = $clog2(DEPTH);
  localparam int WA_W = widx_w(AW);

  logic [DEPTH-1:0][WA_W-1:0]   ent_addr;
  logic [DEPTH-1:0][WORD_W-1:0] ent_data;
  logic [PW-1:0]                head;
  logic [PW-1:0]                tail;
  logic [PW:0]                  count;

  logic                         full;
  logic                         rd_only;
  logic                         drain;
  logic                         push;
  logic                         pop;
  logic                         fwd_hit;
  logic [WORD_W-1:0]            fwd_data;

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .WA_W  (WA_W),
    .PW    (PW)
  ) u_fwd (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .head     (head),
    .count    (count),
    .key      (cpu_addr[AW-1:WORD_LSB]),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );

  // sb_empty comes only from registered occupancy
  assign sb_empty = (count == '0);

  // Port arbitration, load return and stall generation
  always_comb begin
    full      = (count == (PW + 1)'(DEPTH));
    // A simultaneous load+store request is a store; the load half is dropped
    rd_only   = cpu_rd && !cpu_wr;
    // Drain whenever stores are queued and the CPU is not asking for the port,
    // and unconditionally when full so the buffer always makes progress.
    // Held off while reset is asserted so no pending store is ever written.
    drain     = reset && (count != '0) && (full || !cpu_rd);
    pop       = drain;
    push      = cpu_wr && !full;

    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (drain) begin
      mem_wr    = 1'b1;
      mem_addr  = {ent_addr[head], {WORD_LSB{1'b0}}};
      mem_wdata = ent_data[head];
    end else if (rd_only) begin
      mem_rd    = 1'b1;
      mem_addr  = cpu_addr;
    end

    cpu_stall = 1'b0;
    cpu_rdata = '0;
    if (cpu_wr) begin
      cpu_stall = reset && full;
    end else if (cpu_rd) begin
      if (fwd_hit) begin
        // Forwarding is valid even if the matching entry retires this cycle
        cpu_rdata = fwd_data;
      end else if (drain) begin
        cpu_stall = 1'b1;
      end else begin
        cpu_rdata = mem_rdata;
      end
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_addr <= '0;
      ent_data <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        ent_addr[tail] <= cpu_addr[AW-1:WORD_LSB];
        ent_data[tail] <= cpu_wdata;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
